scoreboard_hazard_unit: RTL and testbench

- Next-generation hazard/forwarding controller for the pipelined CPU.
- Replaces fixed load-use detection with a per-register scoreboard of pending-write latency counters. Supports producers of any latency (ALU, load, multi-cycle units).
- Selects forwarding among a parametrised number of post-execute stages.
- Adds a global pipeline freeze for memory wait states.
- Sits beside Decode/Execute and drives the stall/flush controls of every pipeline flip-flop.

---
 rtl/scoreboard_hazard_unit.sv | 139 +++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard and forwarding controller.
// Tracks a pending-write latency counter per register, stalls Decode on
// outstanding producers, freezes the pipe on memory wait states and
// selects the youngest ready forwarding stage for each Execute source.
module scoreboard_hazard_unit #(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned REGNUM       = 16,
  parameter int unsigned STAGES       = 3,
  parameter int unsigned MAXLATENCY   = 7,
  parameter int unsigned LATWIDTH     = $clog2(MAXLATENCY + 1),
  parameter int unsigned FSELWIDTH    = $clog2(STAGES + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             issueValidD,
  input  logic                             writeEnableD,
  input  logic [ADDRESSWIDTH-1:0]          regDestinationAddressD,
  input  logic [ADDRESSWIDTH-1:0]          reg1AddressD,
  input  logic [ADDRESSWIDTH-1:0]          reg2AddressD,
  input  logic                             reg1UsedD,
  input  logic                             reg2UsedD,
  input  logic [LATWIDTH-1:0]              latencyD,
  input  logic [ADDRESSWIDTH-1:0]          reg1AddressE,
  input  logic [ADDRESSWIDTH-1:0]          reg2AddressE,
  input  logic [STAGES*ADDRESSWIDTH-1:0]   stageDestAddress,
  input  logic [STAGES-1:0]                stageWriteEnable,
  input  logic [STAGES-1:0]                stageResultReady,
  input  logic                             takeBranchE,
  input  logic                             memReadyM,
  output logic                             stallF,
  output logic                             stallD,
  output logic                             flushD,
  output logic                             flushE,
  output logic                             freezeBack,
  output logic [FSELWIDTH-1:0]             data1ForwardSelectorE,
  output logic [FSELWIDTH-1:0]             data2ForwardSelectorE,
  output logic [15:0]                      stallCount
);

  logic [LATWIDTH-1:0] pending [REGNUM];
  logic                freeze;
  logic                hazard;
  logic                issue;
  logic [LATWIDTH-1:0] latencySat;
  logic                fwd1Blocked;
  logic                fwd2Blocked;

  // Youngest matching stage wins; a not-ready youngest match blocks older ones.
  function automatic logic [FSELWIDTH:0] forwardSelect(
    input logic [ADDRESSWIDTH-1:0]        src,
    input logic [STAGES*ADDRESSWIDTH-1:0] dest,
    input logic [STAGES-1:0]              we,
    input logic [STAGES-1:0]              ready
  );
    logic                 found;
    logic                 blocked;
    logic [FSELWIDTH-1:0] sel;
    found   = 1'b0;
    blocked = 1'b0;
    sel     = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (!found && we[k] && (dest[k*int'(ADDRESSWIDTH) +: ADDRESSWIDTH] == src)) begin
        found = 1'b1;
        if (ready[k]) sel = FSELWIDTH'(k + 1);
        else          blocked = 1'b1;
      end
    end
    return {blocked, sel};
  endfunction

  assign freeze     = !memReadyM;
  assign hazard     = issueValidD &&
                      ((reg1UsedD && (pending[reg1AddressD] != '0)) ||
                       (reg2UsedD && (pending[reg2AddressD] != '0)));
  assign issue      = issueValidD && writeEnableD && !freeze && !takeBranchE && !hazard;
  assign latencySat = ({1'b0, latencyD} > (LATWIDTH + 1)'(MAXLATENCY)) ?
                      LATWIDTH'(MAXLATENCY) : latencyD;

  // Pipeline control priority: reset, freeze, branch, scoreboard hazard.
  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    freezeBack = 1'b0;
    if (reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (freeze) begin
      stallF     = 1'b1;
      stallD     = 1'b1;
      freezeBack = 1'b1;
    end else if (takeBranchE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (hazard) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // Forwarding selectors for both Execute sources.
  always_comb begin
    {fwd1Blocked, data1ForwardSelectorE} =
      forwardSelect(reg1AddressE, stageDestAddress, stageWriteEnable, stageResultReady);
    {fwd2Blocked, data2ForwardSelectorE} =
      forwardSelect(reg2AddressE, stageDestAddress, stageWriteEnable, stageResultReady);
  end

  // Pending counters: hold on freeze, else count down; a new issue overrides.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(REGNUM); i++) pending[i] <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < int'(REGNUM); i++) begin
        if (pending[i] != '0) pending[i] <= pending[i] - LATWIDTH'(1);
      end
      if (issue && (latencySat != '0)) pending[regDestinationAddressD] <= latencySat;
    end
  end

  // Saturating count of Decode stall cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount <= '0;
    end else if (stallD && (stallCount != 16'hFFFF)) begin
      stallCount <= stallCount + 16'd1;
    end
  end

  // The scoreboard must never let a consumer reach Execute ahead of its producer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!fwd1Blocked && !fwd2Blocked);
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Randomized self-checking bench for scoreboard_hazard_unit.
// The reference model tracks, per register, the absolute unfrozen-cycle time
// at which its pending write becomes visible, instead of per-register counters.
module tb_scoreboard_hazard_unit;

  logic        clock;
  logic        reset;
  logic        issueValidD;
  logic        writeEnableD;
  logic [3:0]  regDestinationAddressD;
  logic [3:0]  reg1AddressD;
  logic [3:0]  reg2AddressD;
  logic        reg1UsedD;
  logic        reg2UsedD;
  logic [2:0]  latencyD;
  logic [3:0]  reg1AddressE;
  logic [3:0]  reg2AddressE;
  logic [11:0] stageDestAddress;
  logic [2:0]  stageWriteEnable;
  logic [2:0]  stageResultReady;
  logic        takeBranchE;
  logic        memReadyM;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        flushE;
  logic        freezeBack;
  logic [1:0]  data1ForwardSelectorE;
  logic [1:0]  data2ForwardSelectorE;
  logic [15:0] stallCount;

  int          checks = 0;
  int          errors = 0;

  // Model state: unfrozen-cycle clock, per-register visibility time, stall tally.
  longint      activeTime = 0;
  longint      readyAt [16];
  int          modelCount = 0;

  scoreboard_hazard_unit dut (
    .clock                  (clock),
    .reset                  (reset),
    .issueValidD            (issueValidD),
    .writeEnableD           (writeEnableD),
    .regDestinationAddressD (regDestinationAddressD),
    .reg1AddressD           (reg1AddressD),
    .reg2AddressD           (reg2AddressD),
    .reg1UsedD              (reg1UsedD),
    .reg2UsedD              (reg2UsedD),
    .latencyD               (latencyD),
    .reg1AddressE           (reg1AddressE),
    .reg2AddressE           (reg2AddressE),
    .stageDestAddress       (stageDestAddress),
    .stageWriteEnable       (stageWriteEnable),
    .stageResultReady       (stageResultReady),
    .takeBranchE            (takeBranchE),
    .memReadyM              (memReadyM),
    .stallF                 (stallF),
    .stallD                 (stallD),
    .flushD                 (flushD),
    .flushE                 (flushE),
    .freezeBack             (freezeBack),
    .data1ForwardSelectorE  (data1ForwardSelectorE),
    .data2ForwardSelectorE  (data2ForwardSelectorE),
    .stallCount             (stallCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit isPending(input logic [3:0] r);
    return readyAt[r] > activeTime;
  endfunction

  function automatic logic [1:0] expectedForward(input logic [3:0] src);
    for (int k = 0; k < 3; k++) begin
      if (stageWriteEnable[k] && (stageDestAddress[k*4 +: 4] == src)) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  // A producer that matches an Execute source is always ready by the time
  // the consumer sits in Execute; keep the stimulus within that contract.
  task automatic fixReady();
    for (int k = 0; k < 3; k++) begin
      if (stageWriteEnable[k] &&
          ((stageDestAddress[k*4 +: 4] == reg1AddressE) ||
           (stageDestAddress[k*4 +: 4] == reg2AddressE)))
        stageResultReady[k] = 1'b1;
    end
  endtask

  // Check outputs for the inputs already driven this cycle, then advance the model.
  task automatic applyAndCheck();
    bit fz, hz, eStallF, eStallD, eFlushD, eFlushE, eFreeze, doIssue;
    int lat;
    fixReady();
    #1;
    fz = !memReadyM;
    hz = issueValidD && ((reg1UsedD && isPending(reg1AddressD)) ||
                         (reg2UsedD && isPending(reg2AddressD)));
    {eStallF, eStallD, eFlushD, eFlushE, eFreeze} = 5'b0;
    if (reset) begin
      eFlushD = 1; eFlushE = 1;
    end else if (fz) begin
      eStallF = 1; eStallD = 1; eFreeze = 1;
    end else if (takeBranchE) begin
      eFlushD = 1; eFlushE = 1;
    end else if (hz) begin
      eStallF = 1; eStallD = 1; eFlushE = 1;
    end
    checkValue("stallF", 32'(stallF), 32'(eStallF));
    checkValue("stallD", 32'(stallD), 32'(eStallD));
    checkValue("flushD", 32'(flushD), 32'(eFlushD));
    checkValue("flushE", 32'(flushE), 32'(eFlushE));
    checkValue("freezeBack", 32'(freezeBack), 32'(eFreeze));
    checkValue("fwd1", 32'(data1ForwardSelectorE), 32'(expectedForward(reg1AddressE)));
    checkValue("fwd2", 32'(data2ForwardSelectorE), 32'(expectedForward(reg2AddressE)));
    checkValue("stallCount", 32'(stallCount), 32'(modelCount));
    doIssue = issueValidD && writeEnableD && !fz && !takeBranchE && !hz;
    lat = (int'(latencyD) > 7) ? 7 : int'(latencyD);
    @(posedge clock);
    if (reset) begin
      foreach (readyAt[r]) readyAt[r] = activeTime;
      modelCount = 0;
    end else begin
      if (eStallD && modelCount < 65535) modelCount++;
      if (!fz) activeTime++;
      if (doIssue && lat != 0) readyAt[regDestinationAddressD] = activeTime + longint'(lat);
    end
  endtask

  // Directed cycle: Decode/control fields given, Execute and stages idle.
  task automatic driveD(input logic rst, input logic br, input logic rdy,
                        input logic iv, input logic we, input logic [3:0] dst,
                        input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2, input logic [2:0] lat);
    @(negedge clock);
    reset = rst; takeBranchE = br; memReadyM = rdy;
    issueValidD = iv; writeEnableD = we; regDestinationAddressD = dst;
    reg1AddressD = s1; reg1UsedD = u1; reg2AddressD = s2; reg2UsedD = u2;
    latencyD = lat;
    reg1AddressE = 4'd0; reg2AddressE = 4'd0;
    stageDestAddress = 12'd0; stageWriteEnable = 3'd0; stageResultReady = 3'd0;
    applyAndCheck();
  endtask

  function automatic logic [3:0] pickReg();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    foreach (readyAt[r]) readyAt[r] = 0;
    reset = 1'b1; takeBranchE = 1'b0; memReadyM = 1'b1;
    issueValidD = 1'b0; writeEnableD = 1'b0; regDestinationAddressD = 4'd0;
    reg1AddressD = 4'd0; reg2AddressD = 4'd0; reg1UsedD = 1'b0; reg2UsedD = 1'b0;
    latencyD = 3'd0; reg1AddressE = 4'd0; reg2AddressE = 4'd0;
    stageDestAddress = 12'd0; stageWriteEnable = 3'd0; stageResultReady = 3'd0;
    repeat (2) @(posedge clock);

    // Reset state
    repeat (2) driveD(1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 3'd0);

    // Multi-cycle producer of r7 (latency 4) followed by a reader
    driveD(0, 0, 1, 1, 1, 4'd7, 4'd0, 0, 4'd0, 0, 3'd4);
    repeat (6) driveD(0, 0, 1, 1, 0, 4'd0, 4'd7, 1, 4'd0, 0, 3'd0);

    // Load r3 then a stalled reader across a 3-cycle memory freeze
    driveD(0, 0, 1, 1, 1, 4'd3, 4'd0, 0, 4'd0, 0, 3'd3);
    repeat (3) driveD(0, 0, 0, 1, 0, 4'd0, 4'd3, 1, 4'd0, 0, 3'd0);
    repeat (4) driveD(0, 0, 1, 1, 0, 4'd0, 4'd3, 1, 4'd0, 0, 3'd0);

    // Branch squashes a writer of r9; branch under freeze waits
    driveD(0, 1, 1, 1, 1, 4'd9, 4'd0, 0, 4'd0, 0, 3'd5);
    driveD(0, 0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd0, 0, 3'd0);
    driveD(0, 1, 0, 1, 1, 4'd9, 4'd0, 0, 4'd0, 0, 3'd5);
    driveD(0, 1, 1, 1, 1, 4'd9, 4'd0, 0, 4'd0, 0, 3'd5);

    // Reset discards pending r2
    driveD(0, 0, 1, 1, 1, 4'd2, 4'd0, 0, 4'd0, 0, 3'd3);
    driveD(1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 3'd0);
    driveD(0, 0, 1, 1, 0, 4'd0, 4'd2, 1, 4'd0, 0, 3'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset                  = ($urandom_range(0, 99) == 0);
      takeBranchE            = ($urandom_range(0, 99) < 8);
      memReadyM              = ($urandom_range(0, 99) >= 15);
      issueValidD            = ($urandom_range(0, 99) < 80);
      writeEnableD           = ($urandom_range(0, 99) < 70);
      regDestinationAddressD = pickReg();
      reg1AddressD           = pickReg();
      reg2AddressD           = pickReg();
      reg1UsedD              = 1'($urandom_range(0, 1));
      reg2UsedD              = 1'($urandom_range(0, 1));
      latencyD               = 3'($urandom_range(0, 7));
      reg1AddressE           = pickReg();
      reg2AddressE           = pickReg();
      stageWriteEnable       = 3'($urandom_range(0, 7));
      stageResultReady       = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) stageDestAddress[k*4 +: 4] = pickReg();
      applyAndCheck();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
